lc3_operate_ctrl: RTL and testbench
===================================

# lc3_operate_ctrl

Multi-cycle sequencer that executes LC-3 operate instructions (ADD, AND, NOT) on the shared 16-bit ALU. It accepts one instruction per valid/ready handshake, reads operands from the register file, and drives the ALU operation select and operands. It then writes the result back and updates the NZP condition codes. It sits between the instruction source (fetch/decode or testbench) and the ALU / register file.

## Interface
- No parameters; widths are fixed by the LC-3 ISA (16-bit data, 3-bit register index).
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr  in  16  LC-3 instruction word; sampled only on handshake.
- instr_ready  out  1  high only in IDLE.
- SR1  out  3  register-file read address A, IR[8:6].
- SR2  out  3  register-file read address B, IR[2:0].
- SR1OUT  in  16  register-file read data A; combinational read.
- SR2OUT  in  16  register-file read data B; combinational read.
- ALU_signal  out  2  ALU op: 00 ADD, 01 AND, 10 NOT, 11 PASS.
- alu_a  out  16  ALU operand A (SR1OUT_in).
- alu_b  out  16  ALU operand B (SR2MUXOUT_in).
- ALU_OUT  in  16  ALU result; combinational.
- LD_REG  out  1  register-file write enable.
- DR  out  3  write address, IR[11:9].
- wb_data  out  16  write data.
- NZP  out  3  condition codes {N,Z,P}.
- done  out  1  one-cycle pulse on retirement.
- illegal  out  1  one-cycle pulse on rejected opcode.

## Operation
- State machine with states IDLE, READ, EXEC, WB, ERR.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr into IR.
  - Go to READ if IR[15:12] is 0001 (ADD), 0101 (AND) or 1001 (NOT); otherwise go to ERR.
- READ:
  - SR1/SR2 are driven from IR.
  - Register opA←SR1OUT.
  - For ADD/AND with IR[5]=1, register opB←sext(IR[4:0]) to 16 bits; otherwise opB←SR2OUT.
  - Next state is EXEC.
- EXEC:
  - alu_a=opA, alu_b=opB.
  - ALU_signal=00/01/10 for ADD/AND/NOT.
  - Register result←ALU_OUT.
  - Next state is WB.
- WB:
  - LD_REG=1, DR=IR[11:9], wb_data=result, done=1.
  - At the clock edge, NZP←{result[15], result==0, !result[15]&&result!=0}.
  - Next state is IDLE.
- ERR: illegal=1, no register write, NZP unchanged; next state is IDLE.
- Idle output values:
  - Outside EXEC, ALU_signal=11 and alu_a/alu_b=0.
  - Outside WB, LD_REG=0.
  - SR1/SR2/DR always reflect IR.
- Arithmetic: ADD wraps modulo 2^16; no overflow flag.
- NOT ignores IR[5:0]; a NOT with IR[5:0]≠111111 is still executed.
- NZP is modified only in WB; ERR and reset-abort leave it untouched except by Reset itself.

## Timing
- Reset values:
  - state=IDLE, IR=0, opA/opB/result=0.
  - NZP=3'b010.
  - instr_ready=1, LD_REG=0, done=0, illegal=0, ALU_signal=11.
- Handshake accepted at edge E0 → READ in cycle 1, EXEC in cycle 2, WB (LD_REG/done high) in cycle 3, IDLE in cycle 4.
  - Write and NZP commit at edge E4.
  - Throughput is one instruction per 4 cycles.
- Illegal opcode: ERR in cycle 1 (illegal high), IDLE in cycle 2.
- instr_valid while not in IDLE is ignored; instr must be held by the source until accepted.
- Back-to-back dependency: the next READ occurs at least one cycle after the WB write edge, so read-after-write needs no forwarding.
- Reset asserted in any state returns to IDLE at the next edge, with no LD_REG, done or illegal pulse in the following cycle. A result pending in EXEC/WB is discarded.

## Structure
- Shared package lc3_pkg:
  - opcode constants OP_ADD=4'b0001, OP_AND=4'b0101, OP_NOT=4'b1001;
  - ALU op enum ALU_ADD=2'b00, ALU_AND=2'b01, ALU_NOT=2'b10, ALU_PASS=2'b11;
  - state enum;
  - sext5 function.
- One natural sub-module: nzp_reg (16-bit result in, load enable, 3-bit NZP register, reset 010); it is reused later by load instructions.
- The ALU and register file stay external; this block does not instantiate them.

## Test plan
- Reset, then ADD R2,R0,R1 (0x1401) with R0=5, R1=7 → in WB cycle 3: LD_REG=1, DR=2, wb_data=12, NZP=001 after E4; ALU_signal=00 only in cycle 2.
- AND R3,R3,#0 (0x56E0) with R3=0xFFFF → wb_data=0, NZP=010; ADD R1,R1,#-1 (0x127F) with R1=0 → wb_data=0xFFFF, NZP=100 (sext check).
- NOT R4,R5 (0x997F) with R5=0x00F0 → wb_data=0xFF0F, ALU_signal=10 in EXEC, NZP=100.
- Illegal 0x2000 (LD) → illegal pulse in cycle 1, LD_REG never high, NZP unchanged, instr_ready high in cycle 2.
- instr_valid held continuously with two dependent ADDs (R1←R1+1 twice, R1=0) → second accepted exactly 4 cycles after first; it reads R1=1 and writes 2.
- Reset asserted during EXEC → IDLE next cycle, no LD_REG/done, NZP=010.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg
// Shared LC-3 definitions for the operate-instruction sequencer and its
// helpers:
//   - opcode constants for the operate instructions (ADD, AND, NOT)
//   - the ALU operation encoding driven onto ALU_signal
//   - the sequencer state encoding
//   - small decode helpers (immediate sign extension, opcode checks)
package lc3_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_WB   = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Sign-extend the 5-bit immediate of ADD/AND to a full data word.
    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

    // True for the opcodes this sequencer knows how to execute.
    function automatic logic is_operate(input logic [3:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    endfunction

    // ALU operation for an accepted operate opcode; PASS for anything else.
    function automatic alu_op_t alu_op_for(input logic [3:0] opcode);
        alu_op_t op;
        op = ALU_PASS;
        if (opcode == OP_ADD) op = ALU_ADD;
        if (opcode == OP_AND) op = ALU_AND;
        if (opcode == OP_NOT) op = ALU_NOT;
        return op;
    endfunction

endpackage

// File: rtl/lc3_operate_ctrl_if.sv
// lc3_operate_ctrl_if
// Bundles every non-clock signal between the operate sequencer and its
// surroundings (instruction source, register file, ALU).
//   instr_valid / instr / instr_ready : instruction handshake
//   SR1 / SR2 / SR1OUT / SR2OUT       : register-file reads (combinational)
//   ALU_signal / alu_a / alu_b / ALU_OUT : shared ALU drive and result
//   LD_REG / DR / wb_data             : register-file write port
//   NZP                               : condition codes
//   done / illegal                    : retirement / rejection pulses
// The master modport is the sequencer; the slave modport is the environment.
interface lc3_operate_ctrl_if;

    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;

    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic [15:0] SR1OUT;
    logic [15:0] SR2OUT;

    logic [1:0]  ALU_signal;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] ALU_OUT;

    logic        LD_REG;
    logic [2:0]  DR;
    logic [15:0] wb_data;

    logic [2:0]  NZP;
    logic        done;
    logic        illegal;

    modport master (
        input  instr_valid, instr, SR1OUT, SR2OUT, ALU_OUT,
        output instr_ready, SR1, SR2, ALU_signal, alu_a, alu_b,
               LD_REG, DR, wb_data, NZP, done, illegal
    );

    modport slave (
        output instr_valid, instr, SR1OUT, SR2OUT, ALU_OUT,
        input  instr_ready, SR1, SR2, ALU_signal, alu_a, alu_b,
               LD_REG, DR, wb_data, NZP, done, illegal
    );

endinterface

// File: rtl/lc3_operate_ctrl_nzp_reg.sv
// nzp_reg
// LC-3 condition-code register. When load is high the {N,Z,P} flags are
// recomputed from the 16-bit value being written back; otherwise they hold.
// Reset leaves the register with Z set (3'b010).
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   result : value whose sign/zero status sets the flags
//   load   : update enable
//   nzp    : {N,Z,P}
module nzp_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result,
    input  logic        load,
    output logic [2:0]  nzp
);

    // Exactly one flag is ever set: negative, zero, or strictly positive.
    always_ff @(posedge clk) begin
        if (reset) begin
            nzp <= 3'b010;
        end else if (load) begin
            nzp <= {result[15],
                    result == 16'h0000,
                    !result[15] && (result != 16'h0000)};
        end
    end

endmodule

// File: rtl/lc3_operate_ctrl.sv
// lc3_operate_ctrl
// Multi-cycle sequencer for the LC-3 operate instructions ADD, AND and NOT.
// One instruction is accepted per handshake in IDLE, then walks through
// READ (capture operands), EXEC (drive the shared ALU), WB (write back and
// update NZP). Any other opcode visits ERR for one cycle and is dropped.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : lc3_operate_ctrl_if.master (handshake, register-file read
//                and write ports, ALU drive/result, NZP, done, illegal)
module lc3_operate_ctrl
    import lc3_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    lc3_operate_ctrl_if.master        bus
);

    state_t      state;
    logic [15:0] ir;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] result;

    logic        ready_q;
    logic        ld_reg_q;
    logic        done_q;
    logic        illegal_q;
    alu_op_t     alu_sel_q;

    logic [3:0]  opcode;
    logic        use_imm;
    logic [15:0] opb_next;

    assign opcode   = ir[15:12];
    // NOT has bit 5 set in its encoding but never takes an immediate.
    assign use_imm  = ir[5] && (opcode != OP_NOT);
    assign opb_next = use_imm ? sext5(ir[4:0]) : bus.SR2OUT;

    // Main sequencer. Every output flag is registered alongside the state
    // transition into the state that owns it, so outputs are glitch-free and
    // line up exactly with the state they belong to. The operand registers
    // double as the ALU operand outputs: they are loaded on entry to EXEC and
    // cleared on leaving it, which keeps the ALU inputs quiet at all other
    // times. A reset in any state drops whatever instruction was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ir        <= 16'h0000;
            opa       <= 16'h0000;
            opb       <= 16'h0000;
            result    <= 16'h0000;
            ready_q   <= 1'b1;
            ld_reg_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            alu_sel_q <= ALU_PASS;
        end else begin
            ld_reg_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid && ready_q) begin
                        ir      <= bus.instr;
                        ready_q <= 1'b0;
                        if (is_operate(bus.instr[15:12])) begin
                            state <= ST_READ;
                        end else begin
                            state     <= ST_ERR;
                            illegal_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    opa       <= bus.SR1OUT;
                    opb       <= opb_next;
                    alu_sel_q <= alu_op_for(opcode);
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    result    <= bus.ALU_OUT;
                    opa       <= 16'h0000;
                    opb       <= 16'h0000;
                    alu_sel_q <= ALU_PASS;
                    ld_reg_q  <= 1'b1;
                    done_q    <= 1'b1;
                    state     <= ST_WB;
                end
                ST_WB: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_ERR: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    opa       <= 16'h0000;
                    opb       <= 16'h0000;
                    alu_sel_q <= ALU_PASS;
                    ready_q   <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Flags update on the same edge that ends WB, i.e. together with the
    // register-file write.
    nzp_reg u_nzp (
        .clk    (clk),
        .reset  (reset),
        .result (result),
        .load   (ld_reg_q),
        .nzp    (bus.NZP)
    );

    assign bus.instr_ready = ready_q;
    assign bus.SR1         = ir[8:6];
    assign bus.SR2         = ir[2:0];
    assign bus.DR          = ir[11:9];
    assign bus.ALU_signal  = alu_sel_q;
    assign bus.alu_a       = opa;
    assign bus.alu_b       = opb;
    assign bus.LD_REG      = ld_reg_q;
    assign bus.wb_data     = result;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_lc3_operate_ctrl.sv
// tb_lc3_operate_ctrl
// Directed bench for lc3_operate_ctrl. Provides a small register file and a
// behavioural ALU around the sequencer, then steps through hand-computed
// instruction sequences checking outputs cycle by cycle.
module tb_lc3_operate_ctrl;

    logic clk = 1'b0;
    logic reset;

    lc3_operate_ctrl_if bus ();

    lc3_operate_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register file: combinational reads, write on the clock edge either
    // from the sequencer or from a bench preload.
    logic [15:0] regs [8];
    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)
            regs[pre_addr] <= pre_data;
        else if (bus.LD_REG)
            regs[bus.DR] <= bus.wb_data;
    end

    assign bus.SR1OUT = regs[bus.SR1];
    assign bus.SR2OUT = regs[bus.SR2];

    // Behavioural ALU.
    always_comb begin
        bus.ALU_OUT = bus.alu_a;
        case (bus.ALU_signal)
            2'b00:   bus.ALU_OUT = bus.alu_a + bus.alu_b;
            2'b01:   bus.ALU_OUT = bus.alu_a & bus.alu_b;
            2'b10:   bus.ALU_OUT = ~bus.alu_a;
            default: bus.ALU_OUT = bus.alu_a;
        endcase
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setReg(input logic [2:0] addr, input logic [15:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        tick();
        pre_we   = 1'b0;
    endtask

    // Offer one instruction for a single cycle; returns in cycle 1.
    task automatic applyStimulus(input logic [15:0] word);
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    // Full operate instruction, checked in each of its four cycles.
    task automatic runOperate(input string tag, input logic [15:0] word,
                              input logic [1:0] alu, input logic [15:0] a,
                              input logic [15:0] b, input logic [2:0] dr,
                              input logic [15:0] wb, input logic [2:0] nzp);
        applyStimulus(word);
        checkOutput({tag, ".c1_ready"}, 16'(bus.instr_ready), 16'd0);
        checkOutput({tag, ".c1_alu"}, 16'(bus.ALU_signal), 16'd3);
        tick();
        checkOutput({tag, ".c2_alu"}, 16'(bus.ALU_signal), 16'(alu));
        checkOutput({tag, ".c2_a"}, bus.alu_a, a);
        checkOutput({tag, ".c2_b"}, bus.alu_b, b);
        checkOutput({tag, ".c2_ld"}, 16'(bus.LD_REG), 16'd0);
        tick();
        checkOutput({tag, ".c3_ld"}, 16'(bus.LD_REG), 16'd1);
        checkOutput({tag, ".c3_done"}, 16'(bus.done), 16'd1);
        checkOutput({tag, ".c3_dr"}, 16'(bus.DR), 16'(dr));
        checkOutput({tag, ".c3_wb"}, bus.wb_data, wb);
        checkOutput({tag, ".c3_alu"}, 16'(bus.ALU_signal), 16'd3);
        checkOutput({tag, ".c3_a"}, bus.alu_a, 16'h0000);
        tick();
        checkOutput({tag, ".c4_nzp"}, 16'(bus.NZP), 16'(nzp));
        checkOutput({tag, ".c4_ready"}, 16'(bus.instr_ready), 16'd1);
        checkOutput({tag, ".c4_ld"}, 16'(bus.LD_REG), 16'd0);
        checkOutput({tag, ".c4_done"}, 16'(bus.done), 16'd0);
        checkOutput({tag, ".c4_reg"}, regs[dr], wb);
    endtask

    // Directed sequence.
    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        pre_we          = 1'b0;
        pre_addr        = 3'd0;
        pre_data        = 16'h0000;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;

        tick();
        tick();
        checkOutput("rst.ready", 16'(bus.instr_ready), 16'd1);
        checkOutput("rst.ld", 16'(bus.LD_REG), 16'd0);
        checkOutput("rst.done", 16'(bus.done), 16'd0);
        checkOutput("rst.illegal", 16'(bus.illegal), 16'd0);
        checkOutput("rst.alu", 16'(bus.ALU_signal), 16'd3);
        checkOutput("rst.nzp", 16'(bus.NZP), 16'b010);
        checkOutput("rst.wb", bus.wb_data, 16'h0000);
        checkOutput("rst.dr", 16'(bus.DR), 16'd0);
        reset = 1'b0;

        // ADD R2,R0,R1 with R0=5, R1=7
        setReg(3'd0, 16'd5);
        setReg(3'd1, 16'd7);
        runOperate("add_rr", 16'h1401, 2'b00, 16'd5, 16'd7, 3'd2, 16'd12, 3'b001);

        // AND R3,R3,#0 with R3=FFFF
        setReg(3'd3, 16'hFFFF);
        runOperate("and_imm0", 16'h56E0, 2'b01, 16'hFFFF, 16'h0000, 3'd3, 16'h0000, 3'b010);

        // ADD R1,R1,#-1 with R1=0 (immediate sign extension, wraparound)
        setReg(3'd1, 16'h0000);
        runOperate("add_m1", 16'h127F, 2'b00, 16'h0000, 16'hFFFF, 3'd1, 16'hFFFF, 3'b100);

        // NOT R4,R5 with R5=00F0; operand B comes from R7 (ignored by ALU)
        setReg(3'd5, 16'h00F0);
        setReg(3'd7, 16'h1234);
        runOperate("not", 16'h997F, 2'b10, 16'h00F0, 16'h1234, 3'd4, 16'hFF0F, 3'b100);

        // NOT R3,R5 with IR[5:0]=000000 still executes
        runOperate("not_low0", 16'h9740, 2'b10, 16'h00F0, 16'h0005, 3'd3, 16'hFF0F, 3'b100);

        // Illegal opcode (LD)
        applyStimulus(16'h2000);
        checkOutput("ill.c1_illegal", 16'(bus.illegal), 16'd1);
        checkOutput("ill.c1_ready", 16'(bus.instr_ready), 16'd0);
        checkOutput("ill.c1_ld", 16'(bus.LD_REG), 16'd0);
        checkOutput("ill.c1_done", 16'(bus.done), 16'd0);
        checkOutput("ill.c1_nzp", 16'(bus.NZP), 16'b100);
        tick();
        checkOutput("ill.c2_illegal", 16'(bus.illegal), 16'd0);
        checkOutput("ill.c2_ready", 16'(bus.instr_ready), 16'd1);
        checkOutput("ill.c2_ld", 16'(bus.LD_REG), 16'd0);
        checkOutput("ill.c2_nzp", 16'(bus.NZP), 16'b100);

        // Two dependent ADD R1,R1,#1 with instr_valid held high
        setReg(3'd1, 16'h0000);
        bus.instr       = 16'h1261;
        bus.instr_valid = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            checkOutput("b2b.busy", 16'(bus.instr_ready), 16'd0);
            if (c == 3) checkOutput("b2b.first_wb", bus.wb_data, 16'd1);
            tick();
        end
        checkOutput("b2b.c4_ready", 16'(bus.instr_ready), 16'd1);
        checkOutput("b2b.c4_r1", regs[1], 16'd1);
        tick();
        bus.instr_valid = 1'b0;
        checkOutput("b2b.c5_ready", 16'(bus.instr_ready), 16'd0);
        tick();
        checkOutput("b2b.c6_alu", 16'(bus.ALU_signal), 16'd0);
        checkOutput("b2b.c6_a", bus.alu_a, 16'd1);
        tick();
        checkOutput("b2b.c7_done", 16'(bus.done), 16'd1);
        checkOutput("b2b.c7_wb", bus.wb_data, 16'd2);
        tick();
        checkOutput("b2b.c8_r1", regs[1], 16'd2);
        checkOutput("b2b.c8_nzp", 16'(bus.NZP), 16'b001);

        // Reset during EXEC discards the pending ADD R2,R0,R1
        applyStimulus(16'h1401);
        tick();
        checkOutput("rexec.c2_alu", 16'(bus.ALU_signal), 16'd0);
        reset = 1'b1;
        tick();
        checkOutput("rexec.ld", 16'(bus.LD_REG), 16'd0);
        checkOutput("rexec.done", 16'(bus.done), 16'd0);
        checkOutput("rexec.illegal", 16'(bus.illegal), 16'd0);
        checkOutput("rexec.ready", 16'(bus.instr_ready), 16'd1);
        checkOutput("rexec.nzp", 16'(bus.NZP), 16'b010);
        checkOutput("rexec.alu", 16'(bus.ALU_signal), 16'd3);
        reset = 1'b0;
        tick();
        checkOutput("rexec.post_ld", 16'(bus.LD_REG), 16'd0);
        checkOutput("rexec.post_done", 16'(bus.done), 16'd0);
        checkOutput("rexec.r2", regs[2], 16'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
